// File: rtl/aes_key_sched_ctrl.sv
// Sequencing controller for the AES-128 key expansion datapath.
// Steps the key generator through rounds 1..NUM_ROUNDS and hands each round key out over valid/ready.
module aes_key_sched_ctrl #(
    parameter int unsigned NUM_ROUNDS = 10,
    parameter logic [7:0]  RCON_INIT  = 8'h01
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        abort,
    input  logic        rkey_ready,
    output logic        rkey_valid,
    output logic [3:0]  round_o,
    output logic        busy,
    output logic        done,
    output logic        kg_en,
    output logic        kg_next_rnd,
    output logic        kg_gen_key,
    output logic [31:0] kg_rcon
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_EXPAND,
        S_PRESENT,
        S_DONE
    } state_t;

    localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [3:0]  r_round;
    logic [3:0]  w_round_nxt;
    logic [7:0]  r_rcon;
    logic [7:0]  w_rcon_nxt;
    logic        w_busy;

    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_round <= 4'd0;
            r_rcon  <= RCON_INIT;
        end else begin
            r_state <= w_state_nxt;
            r_round <= w_round_nxt;
            r_rcon  <= w_rcon_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_round_nxt = r_round;
        w_rcon_nxt  = r_rcon;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = S_LOAD;
                    w_round_nxt = 4'd1;
                    w_rcon_nxt  = RCON_INIT;
                end
            end
            S_LOAD:   w_state_nxt = S_EXPAND;
            S_EXPAND: w_state_nxt = S_PRESENT;
            S_PRESENT: begin
                if (rkey_ready) begin
                    if (r_round < LAST_ROUND) begin
                        w_state_nxt = S_LOAD;
                        w_round_nxt = r_round + 4'd1;
                        w_rcon_nxt  = xtime(r_rcon);
                    end else begin
                        w_state_nxt = S_DONE;
                    end
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
                w_round_nxt = 4'd0;
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_round_nxt = 4'd0;
            end
        endcase
        // abort wins over start and a same-cycle handshake; rcon is left for the next start to reload
        if (abort) begin
            w_state_nxt = S_IDLE;
            w_round_nxt = 4'd0;
            w_rcon_nxt  = r_rcon;
        end
    end

    always_comb begin
        w_busy      = (r_state == S_LOAD) || (r_state == S_EXPAND) || (r_state == S_PRESENT);
        busy        = w_busy;
        kg_gen_key  = w_busy;
        kg_en       = (r_state == S_LOAD) || (r_state == S_EXPAND);
        kg_next_rnd = (r_state == S_LOAD) && (r_round != 4'd1);
        rkey_valid  = (r_state == S_PRESENT);
        done        = (r_state == S_DONE);
        round_o     = w_busy ? r_round : 4'd0;
        kg_rcon     = w_busy ? {r_rcon, 24'h0} : 32'h0;
    end

endmodule

// File: tb/tb_aes_key_sched_ctrl.sv
// Scoreboard bench for aes_key_sched_ctrl: driver pushes the expected round schedule,
// a negedge monitor pops and checks it whenever a round key is handed off or done pulses.
module tb_aes_key_sched_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        abort;
    logic        rkey_ready;
    logic        rkey_valid;
    logic [3:0]  round_o;
    logic        busy;
    logic        done;
    logic        kg_en;
    logic        kg_next_rnd;
    logic        kg_gen_key;
    logic [31:0] kg_rcon;

    aes_key_sched_ctrl #(.NUM_ROUNDS(10), .RCON_INIT(8'h01)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .rkey_ready(rkey_ready),
        .rkey_valid(rkey_valid), .round_o(round_o), .busy(busy), .done(done),
        .kg_en(kg_en), .kg_next_rnd(kg_next_rnd), .kg_gen_key(kg_gen_key), .kg_rcon(kg_rcon)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    logic [7:0] rcon_tab [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                  8'h20, 8'h40, 8'h80, 8'h1B, 8'h36};

    typedef struct packed {
        logic       is_done;
        logic [3:0] rnd;
        logic [7:0] rcon;
    } exp_t;

    exp_t sb[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [63:0] all_outs();
        return {22'h0, rkey_valid, busy, done, kg_en, kg_next_rnd, kg_gen_key, round_o, kg_rcon};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_schedule();
        exp_t e;
        for (int r = 1; r <= 10; r++) begin
            e.is_done = 1'b0;
            e.rnd     = 4'(r);
            e.rcon    = rcon_tab[r-1];
            sb.push_back(e);
        end
        e.is_done = 1'b1;
        e.rnd     = 4'd0;
        e.rcon    = 8'h00;
        sb.push_back(e);
    endtask

    // ---------------- monitor ----------------
    logic       prev_valid = 1'b0, prev_ready = 1'b0, prev_abort = 1'b0, prev_kg_en = 1'b0;
    logic [3:0] prev_round = 4'd0;
    int         exp_valid_cyc = -1;
    int         exp_done_cyc  = -1;

    always @(negedge clk) begin
        exp_t h;
        if (rst) begin
            prev_valid = 1'b0; prev_ready = 1'b0; prev_abort = 1'b0; prev_kg_en = 1'b0;
            exp_valid_cyc = -1;
            exp_done_cyc  = -1;
        end else begin
            if (!busy)
                check("idle_outputs", {rkey_valid, kg_en, kg_next_rnd, kg_gen_key, round_o, kg_rcon}, 64'h0);
            if (!busy && !done && start && !abort)
                exp_valid_cyc = cyc + 3;
            if (prev_valid && !prev_ready && !prev_abort) begin
                check("stall_hold", {rkey_valid, kg_en, round_o}, {1'b1, 1'b0, prev_round});
            end else if (rkey_valid) begin
                check("valid_time", cyc, exp_valid_cyc);
            end
            if (kg_en && !prev_kg_en)
                check("load_next_rnd", kg_next_rnd, round_o != 4'd1);
            if (kg_en && prev_kg_en && round_o >= 4'd1 && round_o <= 4'd10)
                check("expand_rcon", {kg_next_rnd, kg_gen_key, kg_rcon},
                      {1'b0, 1'b1, rcon_tab[int'(round_o)-1], 24'h0});
            if (rkey_valid && rkey_ready && !abort) begin
                if (sb.size() == 0 || sb[0].is_done) begin
                    errors++; checks++;
                    $display("FAIL unexpected_handshake: round %0d with no round expected", round_o);
                end else begin
                    h = sb.pop_front();
                    check("hs_round", round_o, h.rnd);
                    check("hs_rcon", {kg_en, kg_rcon}, {1'b0, h.rcon, 24'h0});
                    if (h.rnd == 4'd10) begin
                        exp_done_cyc  = cyc + 1;
                        exp_valid_cyc = -1;
                    end else begin
                        exp_valid_cyc = cyc + 3;
                    end
                end
            end
            if (done) begin
                if (sb.size() == 0 || !sb[0].is_done) begin
                    errors++; checks++;
                    $display("FAIL unexpected_done: got done=1 required done=0");
                end else begin
                    h = sb.pop_front();
                    check("done_time", cyc, exp_done_cyc);
                end
                exp_done_cyc = -1;
            end
            if (abort) begin
                exp_valid_cyc = -1;
                exp_done_cyc  = -1;
            end
            prev_valid = rkey_valid;
            prev_ready = rkey_ready;
            prev_abort = abort;
            prev_kg_en = kg_en;
            prev_round = round_o;
        end
    end

    // ---------------- driver ----------------
    // mode 0: ready tied high; 1: 5-cycle stall at round 4; 2: random ready and stray starts
    task automatic run(input int mode, output int lat);
        int t;
        int stall;
        push_schedule();
        rkey_ready = 1'b1;
        start = 1'b1;
        t = cyc;
        tick();
        start = 1'b0;
        lat = -1;
        stall = 0;
        for (int k = 0; k < 400; k++) begin
            if (done) begin
                lat = cyc - t;
                break;
            end
            case (mode)
                1: begin
                    if (rkey_valid && round_o == 4'd4 && stall < 5) begin
                        rkey_ready = 1'b0;
                        stall++;
                    end else begin
                        rkey_ready = 1'b1;
                    end
                end
                2: begin
                    rkey_ready = ($urandom_range(0, 3) != 0);
                    start      = ($urandom_range(0, 5) == 0);
                end
                default: rkey_ready = 1'b1;
            endcase
            tick();
        end
        if (lat < 0) begin
            errors++; checks++;
            $display("FAIL run_timeout: got no done within 400 cycles, required done (mode %0d)", mode);
            sb.delete();
        end else begin
            start = 1'b1;
            tick();
            start = 1'b0;
            rkey_ready = 1'b1;
            check("start_in_done_ignored", busy, 1'b0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running, required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int  lat;
        int  t;
        bit  found;
        bit  done_seen;
        rst = 1'b1; start = 1'b0; abort = 1'b0; rkey_ready = 1'b0;
        repeat (3) tick();
        check("reset_outputs", all_outs(), 64'h0);
        rst = 1'b0;
        tick();
        check("idle_after_reset", all_outs(), 64'h0);

        run(0, lat);
        check("latency_ready_high", lat, 31);
        run(1, lat);
        check("latency_backpressure", lat, 36);
        for (int i = 0; i < 3; i++) run(2, lat);

        // abort during EXPAND of round 6
        push_schedule();
        rkey_ready = 1'b1;
        start = 1'b1;
        t = cyc;
        tick();
        start = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 100; k++) begin
            if (kg_en && !kg_next_rnd && round_o == 4'd6) begin
                check("abort_point", cyc - t, 17);
                abort = 1'b1;
                tick();
                abort = 1'b0;
                found = 1'b1;
                break;
            end
            tick();
        end
        sb.delete();
        check("abort_reached", found, 1'b1);
        check("abort_idle", {busy, rkey_valid, round_o}, 6'h0);
        done_seen = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (done) done_seen = 1'b1;
            tick();
        end
        check("abort_no_done", done_seen, 1'b0);
        run(0, lat);
        check("latency_after_abort", lat, 31);

        // start together with abort in IDLE
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        check("start_abort_ignored", busy, 1'b0);
        tick();
        check("start_abort_still_idle", all_outs(), 64'h0);

        // asynchronous reset during PRESENT of round 3
        push_schedule();
        rkey_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 100; k++) begin
            if (rkey_valid && round_o == 4'd3) begin
                rkey_ready = 1'b0;
                found = 1'b1;
                break;
            end
            tick();
        end
        check("reset_point_reached", found, 1'b1);
        check("present_r3_before_reset", {busy, rkey_valid, round_o}, {2'b11, 4'd3});
        #2;
        rst = 1'b1;
        #1;
        check("async_reset_outputs", all_outs(), 64'h0);
        sb.delete();
        tick();
        check("reset_held_outputs", all_outs(), 64'h0);
        rst = 1'b0;
        rkey_ready = 1'b1;
        tick();
        check("idle_after_midrun_reset", busy, 1'b0);
        run(0, lat);
        check("latency_after_reset", lat, 31);
        check("scoreboard_empty", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
